// File: rtl/bus_main_arbiter.sv
// ---------------------------------------------------------------------------
// bus_main_arbiter
//
// Shares the single main-bus slave port between fetch1 (instruction-cache
// line fills, read-only) and memory1 (data-side reads and 4-beat line
// writes). One master owns the bus per transaction; the grant is held until
// the last read beat, the fourth write beat, or an acknowledged error.
//
// Optional feature macro: BMAIN_ARB_RR_EN
//   defined   : round-robin on a tie, using a registered last-owner bit
//               (resets to memory1, so fetch1 wins the first tie).
//   undefined : fixed priority, memory1 over fetch1. memory1 carries the
//               page-table reads issued on behalf of fetch1, so starving it
//               would stall fetch1 itself.
//
// Ports
//   clk_core, reset_n              core clock, synchronous active-low reset
//   fe1_*  / bmain_*_fe1           fetch1 command/read/error handshakes
//   mem1_* / bmain_*_mem1          memory1 command/write/read/error handshakes
//   bmain_* / bslv_*               slave-side command/write/read/error
//   Read data, rlast and write data are wired outside this block.
//
// Handshake rule: a transfer happens in a cycle where valid and ready are
// both high. A master holds valid and its payload stable until ready; ready
// may depend combinationally on valid. Errors complete on error & eack.
//
// FSM state is one-hot {idle, cmd, rdata, wdata}; the state vector is named
// 'state' so checkers can bind to it directly.
// ---------------------------------------------------------------------------
module bus_main_arbiter (
  input  logic        clk_core,
  input  logic        reset_n,
  // fetch1
  input  logic        fe1_cvalid,
  input  logic [26:0] fe1_addr,
  output logic        bmain_cready_fe1,
  input  logic        fe1_rready,
  output logic        bmain_rvalid_fe1,
  output logic        bmain_error_fe1,
  input  logic        fe1_eack,
  // memory1
  input  logic        mem1_cvalid,
  input  logic        mem1_cmd,
  input  logic [26:0] mem1_addr,
  output logic        bmain_cready_mem1,
  input  logic        mem1_wvalid,
  output logic        bmain_wready_mem1,
  input  logic        mem1_rready,
  output logic        bmain_rvalid_mem1,
  output logic        bmain_error_mem1,
  input  logic        mem1_eack,
  // slave side
  output logic        bmain_cvalid,
  input  logic        bslv_cready,
  output logic        bmain_cmd,
  output logic [26:0] bmain_addr,
  output logic        bmain_wvalid,
  input  logic        bslv_wready,
  input  logic        bslv_rvalid,
  output logic        bmain_rready,
  input  logic        bslv_rlast,
  input  logic        bslv_error,
  output logic        bmain_eack
);

  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_CMD   = 4'b0010;
  localparam logic [3:0] ST_RDATA = 4'b0100;
  localparam logic [3:0] ST_WDATA = 4'b1000;

  logic [3:0] state, state_nxt;
  logic       owner_mem1, owner_nxt;   // 1 = memory1 owns the bus
  logic [1:0] wcnt, wcnt_nxt;          // write beats accepted so far
  logic       sel_mem1;                // arbitration result in idle
  logic       any_req;
  logic       cmd_hs, rd_hs, wr_hs, err_done;

  assign any_req = fe1_cvalid | mem1_cvalid;

`ifdef BMAIN_ARB_RR_EN
  logic last_mem1;

  // On a tie the master that did not win last time is chosen.
  always_comb begin
    sel_mem1 = mem1_cvalid;
    if (fe1_cvalid && mem1_cvalid) sel_mem1 = ~last_mem1;
  end

  always_ff @(posedge clk_core) begin
    if (!reset_n)                       last_mem1 <= 1'b1;
    else if (state == ST_IDLE && any_req) last_mem1 <= sel_mem1;
  end
`else
  assign sel_mem1 = mem1_cvalid;
`endif

  // Handshakes are taken from the routed outputs so they match what the
  // slave and the owner actually see.
  assign cmd_hs   = bmain_cvalid & bslv_cready;
  assign rd_hs    = (state == ST_RDATA) & bslv_rvalid & bmain_rready;
  assign wr_hs    = (state == ST_WDATA) & mem1_wvalid & bslv_wready;
  assign err_done = bslv_error & bmain_eack;   // eack is 0 in idle

  // State register
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      owner_mem1 <= 1'b0;
      wcnt       <= 2'd0;
    end else begin
      state      <= state_nxt;
      owner_mem1 <= owner_nxt;
      wcnt       <= wcnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    owner_nxt = owner_mem1;
    wcnt_nxt  = wcnt;
    if (err_done) begin
      state_nxt = ST_IDLE;
      wcnt_nxt  = 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state_nxt = ST_CMD;
            owner_nxt = sel_mem1;
          end
        end
        ST_CMD: begin
          if (cmd_hs) begin
            state_nxt = bmain_cmd ? ST_RDATA : ST_WDATA;
            wcnt_nxt  = 2'd0;
          end
        end
        ST_RDATA: begin
          if (rd_hs && bslv_rlast) state_nxt = ST_IDLE;
        end
        ST_WDATA: begin
          if (wr_hs) begin
            wcnt_nxt = wcnt + 2'd1;
            if (wcnt == 2'd3) state_nxt = ST_IDLE;  // fixed 4-beat line
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          wcnt_nxt  = 2'd0;
        end
      endcase
    end
  end

  // Output routing, purely from registered state and owner
  always_comb begin
    bmain_cready_fe1  = 1'b0;
    bmain_rvalid_fe1  = 1'b0;
    bmain_error_fe1   = 1'b0;
    bmain_cready_mem1 = 1'b0;
    bmain_wready_mem1 = 1'b0;
    bmain_rvalid_mem1 = 1'b0;
    bmain_error_mem1  = 1'b0;
    bmain_cvalid      = 1'b0;
    bmain_cmd         = 1'b0;
    bmain_addr        = 27'd0;
    bmain_wvalid      = 1'b0;
    bmain_rready      = 1'b0;
    bmain_eack        = 1'b0;

    if (state != ST_IDLE) begin
      if (owner_mem1) begin
        bmain_error_mem1 = bslv_error;
        bmain_eack       = mem1_eack;
      end else begin
        bmain_error_fe1  = bslv_error;
        bmain_eack       = fe1_eack;
      end
    end

    case (state)
      ST_CMD: begin
        if (owner_mem1) begin
          bmain_cvalid      = mem1_cvalid;
          bmain_cmd         = mem1_cmd;
          bmain_addr        = mem1_addr;
          bmain_cready_mem1 = bslv_cready;
        end else begin
          bmain_cvalid      = fe1_cvalid;
          bmain_cmd         = 1'b1;        // fetch1 only reads
          bmain_addr        = fe1_addr;
          bmain_cready_fe1  = bslv_cready;
        end
      end
      ST_RDATA: begin
        if (owner_mem1) begin
          bmain_rready      = mem1_rready;
          bmain_rvalid_mem1 = bslv_rvalid;
        end else begin
          bmain_rready      = fe1_rready;
          bmain_rvalid_fe1  = bslv_rvalid;
        end
      end
      ST_WDATA: begin
        // Only memory1 can reach wdata.
        bmain_wvalid      = mem1_wvalid;
        bmain_wready_mem1 = bslv_wready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_main_arbiter.sv
// ---------------------------------------------------------------------------
// Directed bench for bus_main_arbiter. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge. A grant scoreboard holds the
// expected owner of each accepted command in exp_q.
// ---------------------------------------------------------------------------
module tb_bus_main_arbiter;

  logic        clk_core = 1'b0;
  logic        reset_n;
  logic        fe1_cvalid, fe1_rready, fe1_eack;
  logic [26:0] fe1_addr;
  logic        bmain_cready_fe1, bmain_rvalid_fe1, bmain_error_fe1;
  logic        mem1_cvalid, mem1_cmd, mem1_wvalid, mem1_rready, mem1_eack;
  logic [26:0] mem1_addr;
  logic        bmain_cready_mem1, bmain_wready_mem1, bmain_rvalid_mem1, bmain_error_mem1;
  logic        bmain_cvalid, bmain_cmd, bmain_wvalid, bmain_rready, bmain_eack;
  logic [26:0] bmain_addr;
  logic        bslv_cready, bslv_wready, bslv_rvalid, bslv_rlast, bslv_error;

  int n_checks = 0;
  int n_errors = 0;
  int fe1_beats, mem1_beats, wr_beats;
  logic fe1_touch;
  logic [0:0] exp_q[$];   // expected owner per command handshake, 1 = mem1

  logic [11:0] flags;
  assign flags = {bmain_cready_fe1, bmain_rvalid_fe1, bmain_error_fe1,
                  bmain_cready_mem1, bmain_wready_mem1, bmain_rvalid_mem1,
                  bmain_error_mem1, bmain_cvalid, bmain_cmd, bmain_wvalid,
                  bmain_rready, bmain_eack};

  bus_main_arbiter dut (
    .clk_core(clk_core), .reset_n(reset_n),
    .fe1_cvalid(fe1_cvalid), .fe1_addr(fe1_addr), .bmain_cready_fe1(bmain_cready_fe1),
    .fe1_rready(fe1_rready), .bmain_rvalid_fe1(bmain_rvalid_fe1),
    .bmain_error_fe1(bmain_error_fe1), .fe1_eack(fe1_eack),
    .mem1_cvalid(mem1_cvalid), .mem1_cmd(mem1_cmd), .mem1_addr(mem1_addr),
    .bmain_cready_mem1(bmain_cready_mem1), .mem1_wvalid(mem1_wvalid),
    .bmain_wready_mem1(bmain_wready_mem1), .mem1_rready(mem1_rready),
    .bmain_rvalid_mem1(bmain_rvalid_mem1), .bmain_error_mem1(bmain_error_mem1),
    .mem1_eack(mem1_eack),
    .bmain_cvalid(bmain_cvalid), .bslv_cready(bslv_cready), .bmain_cmd(bmain_cmd),
    .bmain_addr(bmain_addr), .bmain_wvalid(bmain_wvalid), .bslv_wready(bslv_wready),
    .bslv_rvalid(bslv_rvalid), .bmain_rready(bmain_rready), .bslv_rlast(bslv_rlast),
    .bslv_error(bslv_error), .bmain_eack(bmain_eack)
  );

  // clock / watchdog
  always #5 clk_core = ~clk_core;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // driver helpers
  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_core);
  endtask

  task automatic idle_inputs();
    fe1_cvalid = 0; fe1_addr = '0; fe1_rready = 0; fe1_eack = 0;
    mem1_cvalid = 0; mem1_cmd = 0; mem1_addr = '0; mem1_wvalid = 0;
    mem1_rready = 0; mem1_eack = 0;
    bslv_cready = 0; bslv_wready = 0; bslv_rvalid = 0; bslv_rlast = 0; bslv_error = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
  endtask

  task automatic clear_counts();
    fe1_beats = 0; mem1_beats = 0; wr_beats = 0; fe1_touch = 0;
  endtask

  // monitors / scoreboard
  always @(negedge clk_core) begin
    if (bmain_rvalid_fe1 && bmain_rready) fe1_beats++;
    if (bmain_rvalid_mem1 && bmain_rready) mem1_beats++;
    if (bmain_wvalid && bmain_wready_mem1) wr_beats++;
    if (bmain_cready_fe1 || bmain_rvalid_fe1 || bmain_error_fe1) fe1_touch = 1;
    if (bmain_cvalid && bslv_cready) begin
      if (exp_q.size() == 0) check_eq("grant_unexpected", 1, 0);
      else check_eq("grant_owner", {31'd0, bmain_cready_mem1}, {31'd0, exp_q.pop_front()});
    end
    // A master dropping cvalid while the arbiter sits in cmd breaks the protocol.
    if (reset_n && dut.state == 4'b0010 && !bmain_cvalid) check_eq("cvalid_withdrawn", 0, 1);
  end

  initial begin
    clear_counts();
    do_reset();
    sample();
    check_eq("reset_flags", {20'd0, flags}, 0);
    check_eq("reset_addr", {5'd0, bmain_addr}, 0);
    check_eq("reset_state", {28'd0, dut.state}, 32'h1);

    // ---- fe1 read, 4 beats ----
    tick();
    clear_counts();
    fe1_cvalid = 1; fe1_addr = 27'h0001000; exp_q.push_back(1'b0);
    sample();
    check_eq("t1_arb_cycle_cvalid", bmain_cvalid, 0);
    tick();
    bslv_cready = 1;
    sample();
    check_eq("t1_cvalid", bmain_cvalid, 1);
    check_eq("t1_cmd", bmain_cmd, 1);
    check_eq("t1_addr", {5'd0, bmain_addr}, 32'h0001000);
    check_eq("t1_cready_mem1", bmain_cready_mem1, 0);
    tick();
    fe1_cvalid = 0; bslv_cready = 0; fe1_rready = 1;
    for (int i = 0; i < 4; i++) begin
      bslv_rvalid = 1; bslv_rlast = (i == 3);
      sample();
      check_eq("t1_rvalid_mem1", bmain_rvalid_mem1, 0);
      tick();
    end
    bslv_rvalid = 0; bslv_rlast = 0; fe1_rready = 0;
    sample();
    check_eq("t1_beats", fe1_beats, 4);
    check_eq("t1_idle", {28'd0, dut.state}, 32'h1);

    // ---- mem1 write, 4 beats with a 2-cycle stall on beat 1 ----
    tick();
    clear_counts();
    mem1_cvalid = 1; mem1_cmd = 0; mem1_addr = 27'h0002000; exp_q.push_back(1'b1);
    tick();
    bslv_cready = 1;
    sample();
    check_eq("t2_cmd", bmain_cmd, 0);
    check_eq("t2_addr", {5'd0, bmain_addr}, 32'h0002000);
    tick();
    begin
      logic [5:0] wr_pat;
      wr_pat = 6'b111001;
      mem1_cvalid = 0; bslv_cready = 0; mem1_wvalid = 1;
      for (int i = 0; i < 6; i++) begin
        bslv_wready = wr_pat[i];
        sample();
        if (i == 1) begin
          check_eq("t2_stall_wvalid", bmain_wvalid, 1);
          check_eq("t2_stall_wready", bmain_wready_mem1, 0);
        end
        tick();
      end
    end
    mem1_wvalid = 0; bslv_wready = 0;
    sample();
    check_eq("t2_wbeats", wr_beats, 4);
    check_eq("t2_idle", {28'd0, dut.state}, 32'h1);
    check_eq("t2_fe1_quiet", fe1_touch, 0);

    // ---- simultaneous requests, 3 rounds ----
    do_reset();
    clear_counts();
`ifdef BMAIN_ARB_RR_EN
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
`else
    exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
`endif
    fe1_cvalid = 1; fe1_addr = 27'h0000100;
    mem1_cvalid = 1; mem1_cmd = 1; mem1_addr = 27'h0000200;
    fe1_rready = 1; mem1_rready = 1;
    for (int r = 0; r < 3; r++) begin
      tick();
      bslv_cready = 1;
      tick();
      bslv_cready = 0; bslv_rvalid = 1; bslv_rlast = 1;
      tick();
      bslv_rvalid = 0; bslv_rlast = 0;
    end
    fe1_cvalid = 0; mem1_cvalid = 0; fe1_rready = 0; mem1_rready = 0;
    sample();
    check_eq("t3_queue_empty", exp_q.size(), 0);
`ifdef BMAIN_ARB_RR_EN
    check_eq("t3_fe1_beats", fe1_beats, 2);
    check_eq("t3_mem1_beats", mem1_beats, 1);
`else
    check_eq("t3_fe1_beats", fe1_beats, 0);
    check_eq("t3_mem1_beats", mem1_beats, 3);
`endif

    // ---- error while idle is ignored ----
    tick();
    bslv_error = 1; fe1_eack = 1; mem1_eack = 1;
    sample();
    check_eq("idle_err_eack", bmain_eack, 0);
    check_eq("idle_err_fe1", bmain_error_fe1, 0);
    check_eq("idle_err_mem1", bmain_error_mem1, 0);
    tick();
    bslv_error = 0; fe1_eack = 0; mem1_eack = 0;

    // ---- error on beat 2 of fe1 read, pending mem1 ----
    fe1_cvalid = 1; fe1_addr = 27'h0003000;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    tick();
    mem1_cvalid = 1; mem1_cmd = 1; mem1_addr = 27'h0004000; bslv_cready = 1;
    tick();
    fe1_cvalid = 0; bslv_cready = 0; fe1_rready = 1;
    bslv_rvalid = 1; bslv_rlast = 0;
    tick();
    bslv_rvalid = 0; bslv_error = 1; fe1_eack = 1;
    sample();
    check_eq("t4_error_fe1", bmain_error_fe1, 1);
    check_eq("t4_eack", bmain_eack, 1);
    check_eq("t4_error_mem1", bmain_error_mem1, 0);
    tick();
    bslv_error = 0; fe1_eack = 0; fe1_rready = 0;
    sample();
    check_eq("t4_idle", {28'd0, dut.state}, 32'h1);
    tick();
    bslv_cready = 1;
    sample();
    check_eq("t4_mem1_cvalid", bmain_cvalid, 1);
    check_eq("t4_mem1_addr", {5'd0, bmain_addr}, 32'h0004000);
    tick();
    mem1_cvalid = 0; bslv_cready = 0; mem1_rready = 1; bslv_rvalid = 1; bslv_rlast = 1;
    tick();
    bslv_rvalid = 0; bslv_rlast = 0; mem1_rready = 0;

    // ---- reset during beat 2 of mem1 write ----
    mem1_cvalid = 1; mem1_cmd = 0; mem1_addr = 27'h0005000; exp_q.push_back(1'b1);
    tick();
    bslv_cready = 1;
    tick();
    mem1_cvalid = 0; bslv_cready = 0; mem1_wvalid = 1; bslv_wready = 1;
    tick();
    reset_n = 0;
    tick();
    mem1_wvalid = 0; bslv_wready = 0;
    sample();
    check_eq("t5_reset_flags", {20'd0, flags}, 0);
    check_eq("t5_reset_state", {28'd0, dut.state}, 32'h1);
    tick();
    reset_n = 1; fe1_cvalid = 1; fe1_addr = 27'h0006000; exp_q.push_back(1'b0);
    sample();
    check_eq("t5_arb_cycle_cvalid", bmain_cvalid, 0);
    tick();
    bslv_cready = 1;
    sample();
    check_eq("t5_fe1_granted", bmain_cready_fe1, 1);
    check_eq("t5_fe1_addr", {5'd0, bmain_addr}, 32'h0006000);
    tick();
    fe1_cvalid = 0; bslv_cready = 0; fe1_rready = 1; bslv_rvalid = 1; bslv_rlast = 1;
    tick();
    bslv_rvalid = 0; bslv_rlast = 0; fe1_rready = 0;
    sample();
    check_eq("t5_idle", {28'd0, dut.state}, 32'h1);
    check_eq("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
